// File: rtl/product_accumulator_if.sv
// Handshake and data bundle for product_accumulator.
// master: the upstream/controlling side; slave: the accumulator itself.
interface product_accumulator_if #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int ACC_W = M + N + 2
);
    logic             clear;
    logic [M+N-1:0]   prod_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] sum;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;

    modport master (
        output clear, prod_in, in_valid, out_ready,
        input  in_ready, sum, out_valid, ovf
    );

    modport slave (
        input  clear, prod_in, in_valid, out_ready,
        output in_ready, sum, out_valid, ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN consecutive products from an upstream
// multiplier and presents the total with a valid/ready handshake.
// Overflow (carry out of the accumulator) is flagged on ovf and is sticky
// until the next accumulation starts or clear is asserted.
// Build option: define ACC_SATURATE_EN to clamp the accumulator at all-ones
// on overflow; by default it wraps modulo 2^ACC_W.
//
// state | meaning
// IDLE  | waiting for the first product of a new result
// ACC   | summing products 2..LEN
// DONE  | result presented, waiting for out_ready
module product_accumulator #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = M + N + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [7:0] LEN_C = 8'(LEN);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf_r;
    logic             out_valid_r;
    logic             in_ready_r;

    logic [M+N-1:0]   prod;
    logic [ACC_W:0]   add_full;
    logic             carry;
    logic             accept;

    assign prod     = bus.prod_in;
    assign add_full = {1'b0, acc} + (ACC_W+1)'(prod);
    assign carry    = add_full[ACC_W];
    assign accept   = bus.in_valid && in_ready_r;

    assign bus.sum       = acc;
    assign bus.ovf       = ovf_r;
    assign bus.out_valid = out_valid_r;
    assign bus.in_ready  = in_ready_r;

    // Sequencer: clear beats both accept and handoff; outputs registered with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (bus.clear) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= ACC_W'(prod);
                        cnt   <= 8'd1;
                        ovf_r <= 1'b0;
                        if (LEN_C == 8'd1) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
`ifdef ACC_SATURATE_EN
                        // Once clamped, any further nonzero add carries again and stays clamped.
                        acc <= carry ? '1 : add_full[ACC_W-1:0];
`else
                        acc <= add_full[ACC_W-1:0];
`endif
                        if (carry) ovf_r <= 1'b1;
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == LEN_C) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // ovf is left as-is here so the consumer can still read it after handoff.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        acc         <= '0;
                        cnt         <= '0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: one default instance
// (M=N=4, LEN=4, ACC_W=10) and one narrow instance (ACC_W=8, LEN=2)
// for overflow behaviour in both wrap and saturate builds.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.M(4), .N(4), .ACC_W(10)) bus_a ();
    product_accumulator_if #(.M(4), .N(4), .ACC_W(8))  bus_b ();

    product_accumulator #(.M(4), .N(4), .LEN(4), .ACC_W(10)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    product_accumulator #(.M(4), .N(4), .LEN(2), .ACC_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

`ifdef ACC_SATURATE_EN
    localparam logic [31:0] B_OVF_SUM = 32'd255;
`else
    localparam logic [31:0] B_OVF_SUM = 32'd44;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [31:0] s, input logic ov, input logic ir, input logic of);
        check({tag, ".sum"},       32'(bus_a.sum),       s);
        check({tag, ".out_valid"}, 32'(bus_a.out_valid), 32'(ov));
        check({tag, ".in_ready"},  32'(bus_a.in_ready),  32'(ir));
        check({tag, ".ovf"},       32'(bus_a.ovf),       32'(of));
    endtask

    task automatic check_b(input string tag, input logic [31:0] s, input logic ov, input logic ir, input logic of);
        check({tag, ".sum"},       32'(bus_b.sum),       s);
        check({tag, ".out_valid"}, 32'(bus_b.out_valid), 32'(ov));
        check({tag, ".in_ready"},  32'(bus_b.in_ready),  32'(ir));
        check({tag, ".ovf"},       32'(bus_b.ovf),       32'(of));
    endtask

    initial begin
        rst = 1'b1;
        bus_a.clear = 1'b0; bus_a.prod_in = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.clear = 1'b0; bus_b.prod_in = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        check_a("reset_a", 0, 1'b0, 1'b1, 1'b0);
        check_b("reset_b", 0, 1'b0, 1'b1, 1'b0);
        #9 rst = 1'b1;
        step();

        // Basic sum 15+20+30+225 = 290, downstream stalled.
        bus_a.in_valid = 1'b1;
        bus_a.prod_in = 8'd15;  step();
        bus_a.prod_in = 8'd20;  step();
        bus_a.prod_in = 8'd30;  step();
        check_a("basic_3rd", 65, 1'b0, 1'b1, 1'b0);
        bus_a.prod_in = 8'd225; step();
        check_a("basic_done", 290, 1'b1, 1'b0, 1'b0);

        // Stall in DONE with in_valid high: nothing consumed, result held.
        bus_a.prod_in = 8'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("stall", 290, 1'b1, 1'b0, 1'b0);
        end
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        step();
        check_a("handoff", 0, 1'b0, 1'b1, 1'b0);
        bus_a.out_ready = 1'b0;

        // Clear after two accepts wins over a concurrent accept.
        bus_a.in_valid = 1'b1;
        bus_a.prod_in = 8'd5; step(); step();
        check_a("pre_clear", 10, 1'b0, 1'b1, 1'b0);
        bus_a.clear = 1'b1; step();
        check_a("clear", 0, 1'b0, 1'b1, 1'b0);
        bus_a.clear = 1'b0;
        bus_a.prod_in = 8'd1;
        step(); step(); step();
        check_a("ones_3rd", 3, 1'b0, 1'b1, 1'b0);
        step();
        check_a("ones_done", 4, 1'b1, 1'b0, 1'b0);
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1; step();
        bus_a.out_ready = 1'b0;
        check_a("ones_handoff", 0, 1'b0, 1'b1, 1'b0);

        // Gappy in_valid: accepts on even cycles only.
        bus_a.prod_in = 8'd3;
        for (int i = 0; i < 7; i++) begin
            bus_a.in_valid = (i % 2 == 0);
            step();
            if (i == 5) check_a("gap_5", 9, 1'b0, 1'b1, 1'b0);
        end
        bus_a.in_valid = 1'b0;
        check_a("gap_done", 12, 1'b1, 1'b0, 1'b0);
        bus_a.out_ready = 1'b1; step();
        bus_a.out_ready = 1'b0;

        // Asynchronous reset mid-accumulation, then a fresh result.
        bus_a.in_valid = 1'b1;
        bus_a.prod_in = 8'd4;
        step(); step(); step();
        check_a("pre_rst", 12, 1'b0, 1'b1, 1'b0);
        bus_a.in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_a("async_rst", 0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.prod_in = 8'd2;
        step(); step(); step();
        check_a("post_rst_3rd", 6, 1'b0, 1'b1, 1'b0);
        step();
        check_a("post_rst_done", 8, 1'b1, 1'b0, 1'b0);
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1; step();
        bus_a.out_ready = 1'b0;

        // Narrow instance: 200+100 overflows 8 bits.
        bus_b.in_valid = 1'b1;
        bus_b.prod_in = 8'd200; step();
        check_b("ovf_1st", 200, 1'b0, 1'b1, 1'b0);
        bus_b.prod_in = 8'd100; step();
        bus_b.in_valid = 1'b0;
        check_b("ovf_done", B_OVF_SUM, 1'b1, 1'b0, 1'b1);
        step();
        check_b("ovf_hold", B_OVF_SUM, 1'b1, 1'b0, 1'b1);
        bus_b.out_ready = 1'b1; step();
        bus_b.out_ready = 1'b0;
        check_b("ovf_handoff", 0, 1'b0, 1'b1, 1'b1);
        bus_b.in_valid = 1'b1;
        bus_b.prod_in = 8'd1; step();
        bus_b.in_valid = 1'b0;
        check_b("ovf_cleared", 1, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
